// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode-stage sequencing controller.
// Produces hold/flush/bubble controls for PC, IF/ID and ID/EX. It detects
// load-use hazards and serializes CSR/FENCE/ECALL-class instructions by
// draining the pipe and isolating them. It also counts how many instructions
// are in flight past decode.
module pipe_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_serial_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic             ex_rd_we_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    input  logic             wb_retire_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             issue_o,
    output logic             ser_busy_o,
    output logic [CNT_W-1:0] inflight_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        SER_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;

    logic lu;
    logic full;
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic issue;

    // Hazard terms: a load in EX whose destination feeds the ID instruction,
    // and the in-flight counter having no room for another issue.
    always_comb begin
        lu = ex_valid_i & ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i != 5'd0) &
             ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));
        full = (cnt == CNT_MAX);
    end

    // Prioritized control decode: memory stall beats redirect beats the
    // serialization states beats the ordinary hazard/issue path.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        issue       = 1'b0;
        state_nx    = state;
        if (mem_busy_i) begin
            pipe_hold = 1'b1;
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
        end else if (ex_redirect_i) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nx    = RUN;
        end else if (state == SER_WAIT) begin
            pc_hold    = 1'b1;
            ifid_flush = 1'b1;
            if (wb_retire_i && cnt == CNT_ONE) begin
                state_nx = RUN;
            end
        end else if (id_valid_i && id_serial_i) begin
            if (cnt == '0) begin
                issue      = 1'b1;
                pc_hold    = 1'b1;
                ifid_flush = 1'b1;
                state_nx   = SER_WAIT;
            end else begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
                state_nx    = DRAIN;
            end
        end else begin
            // A DRAIN whose serial instruction has gone (e.g. flushed) falls back to RUN.
            state_nx = RUN;
            if (id_valid_i && (lu || full)) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                issue = id_valid_i;
            end
        end
    end

    // State and in-flight counter; the counter saturates at both ends so an
    // illegal retire at zero cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (issue && !wb_retire_i && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end else if (wb_retire_i && !issue && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign pc_hold_o     = pc_hold & ~rst;
    assign ifid_hold_o   = ifid_hold & ~rst;
    assign ifid_flush_o  = ifid_flush & ~rst;
    assign idex_bubble_o = idex_bubble & ~rst;
    assign pipe_hold_o   = pipe_hold & ~rst;
    assign issue_o       = issue & ~rst;
    assign ser_busy_o    = (state != RUN) & ~rst;
    assign inflight_o    = rst ? '0 : cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (CNT_W = 2).
// Inputs change on the falling edge; combinational outputs are checked 1ns
// later, and registered outputs reflect the previous rising edge.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_i;
    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_serial_i;
    logic       ex_valid_i;
    logic       ex_is_load_i;
    logic       ex_rd_we_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_redirect_i;
    logic       mem_busy_i;
    logic       wb_retire_i;
    logic       pc_hold_o;
    logic       ifid_hold_o;
    logic       ifid_flush_o;
    logic       idex_bubble_o;
    logic       pipe_hold_o;
    logic       issue_o;
    logic       ser_busy_o;
    logic [1:0] inflight_o;

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold, issue}
    logic [5:0] outs;
    assign outs = {pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, issue_o};

    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_ISSUE  = 6'b000001;
    localparam logic [5:0] O_STALL  = 6'b110100;
    localparam logic [5:0] O_SERISS = 6'b101001;
    localparam logic [5:0] O_SERWT  = 6'b101000;
    localparam logic [5:0] O_REDIR  = 6'b001100;
    localparam logic [5:0] O_MEMB   = 6'b110010;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_ctrl #(.CNT_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_serial_i   (id_serial_i),
        .ex_valid_i    (ex_valid_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rd_we_i    (ex_rd_we_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_redirect_i (ex_redirect_i),
        .mem_busy_i    (mem_busy_i),
        .wb_retire_i   (wb_retire_i),
        .pc_hold_o     (pc_hold_o),
        .ifid_hold_o   (ifid_hold_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_bubble_o (idex_bubble_o),
        .pipe_hold_o   (pipe_hold_o),
        .issue_o       (issue_o),
        .ser_busy_o    (ser_busy_o),
        .inflight_o    (inflight_o)
    );

    always #5 clk = ~clk;

    // Retiring with nothing in flight is an illegal stimulus.
    always @(posedge clk) begin
        if (!rst && wb_retire_i && inflight_o == 2'd0) begin
            $error("[TB] illegal retire with nothing in flight");
        end
    end

    task automatic set_idle();
        id_valid_i    = 1'b0;
        id_rs1_addr_i = 5'd0;
        id_rs2_addr_i = 5'd0;
        id_serial_i   = 1'b0;
        ex_valid_i    = 1'b0;
        ex_is_load_i  = 1'b0;
        ex_rd_we_i    = 1'b0;
        ex_rd_addr_i  = 5'd0;
        ex_redirect_i = 1'b0;
        mem_busy_i    = 1'b0;
        wb_retire_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        id_valid_i = 1'b1;
        #2;
        tests_run++;
        if (outs !== O_NONE) begin
            tests_failed++;
            $display("[TB] FAIL reset_outs got=%b want=%b", outs, O_NONE);
        end
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        tests_run++;
        if (inflight_o !== 2'd0 || ser_busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state got cnt=%0d busy=%b want cnt=0 busy=0", inflight_o, ser_busy_o);
        end
    endtask

    task automatic test_load_use();
        // Load x5 in EX, consumer reads rs2 = x5: one stall cycle.
        @(negedge clk);
        id_valid_i = 1'b1; id_rs2_addr_i = 5'd5;
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_we_i = 1'b1; ex_rd_addr_i = 5'd5;
        #1;
        tests_run++;
        if (outs !== O_STALL) begin
            tests_failed++;
            $display("[TB] FAIL lu_stall got=%b want=%b", outs, O_STALL);
        end
        // Load has moved to MEM; consumer issues.
        @(negedge clk);
        ex_valid_i = 1'b0;
        #1;
        tests_run++;
        if (outs !== O_ISSUE || inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL lu_release got=%b cnt=%0d want=%b cnt=0", outs, inflight_o, O_ISSUE);
        end
        // Same shape with rd = x0: no stall.
        @(negedge clk);
        id_rs2_addr_i = 5'd0;
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd0;
        #1;
        tests_run++;
        if (outs !== O_ISSUE || inflight_o !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL lu_x0 got=%b cnt=%0d want=%b cnt=1", outs, inflight_o, O_ISSUE);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_serial();
        // cnt is 2 here; CSR in ID must drain first.
        id_valid_i = 1'b1; id_serial_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_STALL || inflight_o !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL ser_drain got=%b cnt=%0d want=%b cnt=2", outs, inflight_o, O_STALL);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wb_retire_i = 1'b1;
            #1;
            tests_run++;
            if (outs !== O_STALL || ser_busy_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL ser_drain_hold got=%b busy=%b want=%b busy=1", outs, ser_busy_o, O_STALL);
            end
        end
        @(negedge clk);
        wb_retire_i = 1'b0;
        #1;
        tests_run++;
        if (outs !== O_SERISS || inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL ser_issue got=%b cnt=%0d want=%b cnt=0", outs, inflight_o, O_SERISS);
        end
        @(negedge clk);
        id_valid_i = 1'b0; id_serial_i = 1'b0;
        #1;
        tests_run++;
        if (outs !== O_SERWT || inflight_o !== 2'd1 || ser_busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ser_wait got=%b cnt=%0d busy=%b want=%b cnt=1 busy=1", outs, inflight_o, ser_busy_o, O_SERWT);
        end
        @(negedge clk);
        wb_retire_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_SERWT) begin
            tests_failed++;
            $display("[TB] FAIL ser_retire got=%b want=%b", outs, O_SERWT);
        end
        @(negedge clk);
        wb_retire_i = 1'b0; id_valid_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_ISSUE || ser_busy_o !== 1'b0 || inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL ser_resume got=%b busy=%b cnt=%0d want=%b busy=0 cnt=0", outs, ser_busy_o, inflight_o, O_ISSUE);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_redirect_drain();
        // cnt is 1; enter DRAIN then redirect.
        id_valid_i = 1'b1; id_serial_i = 1'b1;
        @(negedge clk);
        ex_redirect_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_REDIR || ser_busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL redir_drain got=%b busy=%b want=%b busy=1", outs, ser_busy_o, O_REDIR);
        end
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (ser_busy_o !== 1'b0 || inflight_o !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL redir_run got busy=%b cnt=%0d want busy=0 cnt=1", ser_busy_o, inflight_o);
        end
    endtask

    task automatic test_mem_busy();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_busy_i = 1'b1; ex_redirect_i = 1'b1; id_valid_i = 1'b1;
            #1;
            tests_run++;
            if (outs !== O_MEMB) begin
                tests_failed++;
                $display("[TB] FAIL memb_hold%0d got=%b want=%b", i, outs, O_MEMB);
            end
        end
        @(negedge clk);
        mem_busy_i = 1'b0;
        #1;
        tests_run++;
        if (outs !== O_REDIR) begin
            tests_failed++;
            $display("[TB] FAIL memb_flush got=%b want=%b", outs, O_REDIR);
        end
        @(negedge clk);
        set_idle();
        wb_retire_i = 1'b1;
        @(negedge clk);
        wb_retire_i = 1'b0;
        #1;
        tests_run++;
        if (inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL memb_cnt got=%0d want=0", inflight_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_valid_i = 1'b1;
            #1;
            tests_run++;
            if (outs !== O_ISSUE || inflight_o !== 2'(i)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_issue%0d got=%b cnt=%0d want=%b cnt=%0d", i, outs, inflight_o, O_ISSUE, i);
            end
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (outs !== O_STALL || inflight_o !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_full got=%b cnt=%0d want=%b cnt=3", outs, inflight_o, O_STALL);
        end
        // Full still blocks issue while retiring, so the retire drains one.
        @(negedge clk);
        wb_retire_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_STALL) begin
            tests_failed++;
            $display("[TB] FAIL b2b_full_ret got=%b want=%b", outs, O_STALL);
        end
        // Issue plus retire leaves the count unchanged.
        @(negedge clk);
        #1;
        tests_run++;
        if (outs !== O_ISSUE || inflight_o !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_both got=%b cnt=%0d want=%b cnt=2", outs, inflight_o, O_ISSUE);
        end
        @(negedge clk);
        id_valid_i = 1'b0;
        #1;
        tests_run++;
        if (inflight_o !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_both_cnt got=%0d want=2", inflight_o);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (inflight_o !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain got=%0d want=1", inflight_o);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset_ser_wait();
        // cnt is 0: issue a serial instruction to reach SER_WAIT with cnt 1.
        id_valid_i = 1'b1; id_serial_i = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        tests_run++;
        if (ser_busy_o !== 1'b1 || inflight_o !== 2'd1 || outs !== O_SERWT) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre got=%b busy=%b cnt=%0d want=%b busy=1 cnt=1", outs, ser_busy_o, inflight_o, O_SERWT);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_NONE || ser_busy_o !== 1'b0 || inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async got=%b busy=%b cnt=%0d want=000000 busy=0 cnt=0", outs, ser_busy_o, inflight_o);
        end
        @(negedge clk);
        rst = 1'b0;
        id_valid_i = 1'b1;
        #1;
        tests_run++;
        if (outs !== O_ISSUE || ser_busy_o !== 1'b0 || inflight_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_release got=%b busy=%b cnt=%0d want=%b busy=0 cnt=0", outs, ser_busy_o, inflight_o, O_ISSUE);
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_serial();
        test_redirect_drain();
        test_mem_busy();
        test_back_to_back();
        test_reset_ser_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
